// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU issue path: op word layout,
// select encodings, sequencer FSM states and common widths.
package alu_pkg;

    localparam int OP_W   = 25;
    localparam int DATA_W = 8;

    // ALU function select encodings; 3'b110 and 3'b111 are unassigned.
    typedef enum logic [2:0] {
        SEL_CALC  = 3'b000,
        SEL_LOGIC = 3'b001,
        SEL_SHR   = 3'b010,
        SEL_SHL   = 3'b011,
        SEL_ROR   = 3'b100,
        SEL_ROL   = 3'b101
    } alu_select_e;

    // Packed op word, MSB first: {use_acc, cin, sel_logic, sel_calc, select, b, a}.
    // select is kept as raw bits so unassigned encodings survive the FIFO.
    typedef struct packed {
        logic              use_acc;
        logic              cin;
        logic [1:0]        sel_logic;
        logic [1:0]        sel_calc;
        logic [2:0]        select;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

    // The two top encodings (11x) have no ALU function behind them.
    function automatic logic is_illegal_select(input logic [2:0] sel);
        return sel[2] & sel[1];
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Small first-word-fall-through FIFO holding pending ALU op words.
// Head data is visible combinationally so the sequencer can pop and load
// its operand registers on the same edge.
module alu_op_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = OP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    // The extra count bit is what tells full apart from empty when the
    // pointers are equal.
    assign o_full    = (r_count == (PTR_W + 1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_rdata   = r_mem[r_rd_ptr];

    // Storage write; no reset needed since the count guards every read.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue stage for the 8-bit ALU: buffers op words, drives the ALU one op
// at a time, waits out its pipeline latency, captures the result and
// presents it downstream. An accumulator can feed the last accepted
// result back as operand a.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_cin,
    output logic [2:0]        alu_select,
    output logic [1:0]        alu_sel_calc,
    output logic [1:0]        alu_sel_logic,
    output logic              alu_rst,
    input  logic [DATA_W-1:0] alu_final,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_illegal
);

    // Wait counter loaded with ALU_LAT and run down to zero: ALU_LAT+1 edges
    // in WAIT, giving one edge of margin after the ALU output settles.
    localparam int CNT_W = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    seq_state_e        r_state;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_valid;
    logic              r_out_illegal;
    logic              r_illegal_pend;

    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic              r_alu_cin;
    logic [2:0]        r_alu_select;
    logic [1:0]        r_alu_sel_calc;
    logic [1:0]        r_alu_sel_logic;

    logic [OP_W-1:0]   w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_push;
    logic              w_pop;
    alu_op_t           w_head;
    logic [DATA_W-1:0] w_acc_src;
    logic [DATA_W-1:0] w_next_a;

    assign in_ready = ~w_fifo_full;
    assign w_push   = in_valid & ~w_fifo_full;
    assign w_head   = alu_op_t'(w_fifo_rdata);
    assign alu_rst  = rst;

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (OP_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_wdata (in_op),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Pop decision and operand a selection. A pop out of HOLD always
    // coincides with the result handshake, so the result being accepted
    // is forwarded directly instead of the not-yet-updated accumulator.
    always_comb begin
        w_pop     = 1'b0;
        w_acc_src = r_acc;
        if (!w_fifo_empty) begin
            if (r_state == ST_IDLE) begin
                w_pop = 1'b1;
            end else if (r_state == ST_HOLD && out_ready) begin
                w_pop = 1'b1;
            end
        end
        if (r_state == ST_HOLD) begin
            w_acc_src = r_out_result;
        end
        w_next_a = w_head.use_acc ? w_acc_src : w_head.a;
    end

    // ALU operand/select registers: loaded on each pop, held until the next.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_a         <= '0;
            r_alu_b         <= '0;
            r_alu_cin       <= 1'b0;
            r_alu_select    <= '0;
            r_alu_sel_calc  <= '0;
            r_alu_sel_logic <= '0;
            r_illegal_pend  <= 1'b0;
        end else if (w_pop) begin
            r_alu_a         <= w_next_a;
            r_alu_b         <= w_head.b;
            r_alu_cin       <= w_head.cin;
            r_alu_select    <= w_head.select;
            r_alu_sel_calc  <= w_head.sel_calc;
            r_alu_sel_logic <= w_head.sel_logic;
            r_illegal_pend  <= is_illegal_select(w_head.select);
        end
    end

    // Sequencer FSM: issue, wait for the ALU, capture, then hold until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wait_cnt    <= '0;
            r_acc         <= '0;
            r_out_result  <= '0;
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_wait_cnt <= CNT_W'(ALU_LAT);
                        r_state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_out_result  <= alu_final;
                        r_out_illegal <= r_illegal_pend;
                        r_out_valid   <= 1'b1;
                        r_state       <= ST_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= r_out_result;
                        if (w_pop) begin
                            r_wait_cnt <= CNT_W'(ALU_LAT);
                            r_state    <= ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_a         = r_alu_a;
    assign alu_b         = r_alu_b;
    assign alu_cin       = r_alu_cin;
    assign alu_select    = r_alu_select;
    assign alu_sel_calc  = r_alu_sel_calc;
    assign alu_sel_logic = r_alu_sel_logic;
    assign out_valid     = r_out_valid;
    assign out_result    = r_out_result;
    assign out_illegal   = r_out_illegal;

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Upstream issue stage for the 8-bit ALU datapath. It accepts packed ALU operation words over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's operand and select inputs one operation at a time, waits out the ALU's registered latency, and captures the ALU `final` output. The captured result is presented downstream with its own valid/ready handshake, plus an optional accumulator chain that feeds the previous result back as operand `a`.

## Interface
Parameters:
- `DEPTH`, 4: op FIFO entries; power of two, ≥2.
- `ALU_LAT`, 2: edges from the ALU input change to the updated `final` value; ≥1.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: op word valid.
- `in_ready`, out, 1: FIFO not full.
- `in_op`, in, 25: op word `{use_acc[24], cin[23], sel_logic[22:21], sel_calc[20:19], select[18:16], b[15:8], a[7:0]}`.
- `alu_a`, `alu_b`, out, 8: ALU operands, registered.
- `alu_cin`, out, 1: ALU carry-in, registered.
- `alu_select`, out, 3; `alu_sel_calc`, out, 2; `alu_sel_logic`, out, 2: ALU selects, registered.
- `alu_rst`, out, 1: equal to `rst`, combinational pass-through.
- `alu_final`, in, 8: ALU result.
- `out_valid`, in/out: out, 1: result valid.
- `out_ready`, in, 1: downstream accepts.
- `out_result`, out, 8: captured result.
- `out_illegal`, out, 1: the op carried `select` 3'b110 or 3'b111.

## Operation
- FIFO: a push occurs when `in_valid & in_ready`. `in_ready = !full`. Ops in the FIFO are never dropped.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, FIFO non-empty: pop the head, load the `alu_*` registers, load the wait counter, go to WAIT.
  - WAIT: count `ALU_LAT+1` edges, then capture `alu_final` into `out_result`, set `out_valid`, and go to HOLD.
  - HOLD, `out_ready`: clear `out_valid` and update `acc_q <= out_result`. If the FIFO is non-empty, pop and load in the same edge and go to WAIT; otherwise go to IDLE.
  - HOLD, `!out_ready`: hold `out_result`, `out_valid` and `out_illegal` stable.
- Accumulator: when `use_acc=1`, `alu_a` is loaded from `acc_q` instead of the `a` field.
  - If that load coincides with the HOLD handshake edge, `alu_a` takes `out_result` (bypass).
  - `acc_q` resets to 0x00.
- `out_illegal` is set from the popped op's `select` field. The result for such an op is whatever the ALU produces (0x00); it still occupies one result handshake.
- `alu_*` registers hold their values from load until the next pop.

## Timing
- Reset values: `out_valid=0`, `out_result=0x00`, `out_illegal=0`, all `alu_*=0`, `acc_q=0`, FIFO empty, state IDLE, `in_ready=1` after the reset edge.
- Latency with an empty FIFO and IDLE state:
  - Op accepted at edge A.
  - Pop and ALU load at edge A+1.
  - `out_valid` rises at edge A+ALU_LAT+2.
- Throughput: one result per ALU_LAT+2 cycles with `out_ready` held high.
- Push and pop on the same edge: the FIFO count is unchanged and the data stays ordered.
- A push into an empty FIFO is not visible to the FSM until the next edge.
- Read and write pointers wrap modulo DEPTH. Full and empty are distinguished by a count of width log2(DEPTH)+1.
- `rst` asserted during WAIT or HOLD:
  - The in-flight result and all FIFO contents are discarded.
  - `out_valid` is 0 after the reset edge.
  - The ALU is reset simultaneously via `alu_rst`.

## Structure
- Shared package `alu_pkg`:
  - op word typedef with field positions;
  - `select` encodings (CALC=000, LOGIC=001, SHR=010, SHL=011, ROR=100, ROL=101);
  - FSM state enum;
  - op width constant 25.
- One sub-module, `alu_op_fifo` (parameter DEPTH, width 25, push/pop/full/empty). The FSM, accumulator and capture logic sit in the top module.

## Test plan
- Single op: `select`=010, `a`=0x96, one cycle of `in_valid`, ALU_LAT=2 → `out_result`=0x4B at edge A+4, `out_illegal`=0.
- Rotate: `select`=100, `a`=0x81 → 0xC0. Follow it back-to-back with `select`=101, `a`=0x81 → 0x03. Results appear in order, 4 cycles apart.
- Chain: op1 `select`=011, `a`=0x01 → 0x02. op2 `use_acc`=1, `select`=011, `a` field 0xFF → 0x04, exercising the bypass on the HOLD→WAIT edge.
- Backpressure: `out_ready`=0 for 20 cycles while pushing 6 ops.
  - `in_ready` falls after 4 pushes into the FIFO.
  - `out_result` stays stable throughout.
  - On release, all 5 queued results drain in order.
- Illegal: `select`=110 → `out_result`=0x00, `out_illegal`=1. The next legal op clears `out_illegal`.
- Reset during WAIT with 3 ops queued → `out_valid`=0, `in_ready`=1, and no stale result is emitted afterwards.
